vload_wb: RTL and testbench

VLOAD_WB -- requirements
Module: vload_wb

---
 rtl/vload_wb_if.sv | 36 +++
 rtl/vload_wb.sv | 136 +++++++++++++
 tb/tb_vload_wb.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vload_wb_if.sv
// vload_wb_if: command, load-word and register-file write signals of vload_wb.
// Ports: cmd_* (load command + v0 mask), word_* (load data stream), abort,
//        writeAddr/writeVector/writeEnable/done (register file write side).
// slave modport is the vload_wb side, master modport is the requester side.
interface vload_wb_if #(
  parameter int VLEN = 128
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [4:0]      cmd_vd;
  logic [2:0]      cmd_vl;
  logic            cmd_vm;
  logic [VLEN-1:0] v0;
  logic            word_valid;
  logic            word_ready;
  logic [31:0]     word_data;
  logic            abort;
  logic [4:0]      writeAddr;
  logic [VLEN-1:0] writeVector;
  logic [3:0]      writeEnable;
  logic            done;

  modport slave (
    input  cmd_valid, cmd_vd, cmd_vl, cmd_vm, v0,
    input  word_valid, word_data, abort,
    output cmd_ready, word_ready,
    output writeAddr, writeVector, writeEnable, done
  );

  modport master (
    output cmd_valid, cmd_vd, cmd_vl, cmd_vm, v0,
    output word_valid, word_data, abort,
    input  cmd_ready, word_ready,
    input  writeAddr, writeVector, writeEnable, done
  );
endinterface

// File: rtl/vload_wb.sv
// Purpose: gathers up to 4 x 32-bit load words into one vector register write.
// Latency: write cycle 1 cycle after the last accepted word; vl+2 cycles per command.
// Backpressure: cmd_ready only in IDLE, word_ready only in COLLECT.
// Ports: clk, rst (sync, active-high); bus (vload_wb_if.slave) carries the
//        command/v0 inputs, the word stream, abort, and the register file write.
// Optional: define VLOAD_WB_MASK_EN to gate lane strobes with v0 when cmd_vm=0.
module vload_wb #(
  parameter int VLEN = 128
) (
  input  logic        clk,
  input  logic        rst,
  vload_wb_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;

  state_t          r_state;
  logic [2:0]      r_cnt;
  logic [2:0]      r_vl;
  logic [4:0]      r_vd;
  logic            r_vm;
  logic [3:0]      r_v0m;
  logic [VLEN-1:0] r_buf;
  logic [3:0]      r_we;
  logic            r_done;
  logic            r_cmd_ready;
  logic            r_word_ready;

  logic [2:0]      w_vl_clamp;
  logic [3:0]      w_lane_mask;
  logic [3:0]      w_we_final;

  // vl encodings 5..7 behave as a full vector
  assign w_vl_clamp = (bus.cmd_vl > 3'd4) ? 3'd4 : bus.cmd_vl;

  always_comb begin
    w_lane_mask = 4'b0000;
    case (r_vl)
      3'd0:    w_lane_mask = 4'b0000;
      3'd1:    w_lane_mask = 4'b0001;
      3'd2:    w_lane_mask = 4'b0011;
      3'd3:    w_lane_mask = 4'b0111;
      default: w_lane_mask = 4'b1111;
    endcase
  end

`ifdef VLOAD_WB_MASK_EN
  // masked elements are still consumed, only their strobes drop
  assign w_we_final = r_vm ? w_lane_mask : (w_lane_mask & r_v0m);
  logic w_unused_v0;
  assign w_unused_v0 = ^bus.v0[VLEN-1:4];
`else
  assign w_we_final = w_lane_mask;
  logic w_unused_mask;
  assign w_unused_mask = ^{bus.v0, bus.cmd_vm, r_vm, r_v0m};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= 3'd0;
      r_vl         <= 3'd0;
      r_vd         <= 5'd0;
      r_vm         <= 1'b0;
      r_v0m        <= 4'd0;
      r_buf        <= '0;
      r_we         <= 4'd0;
      r_done       <= 1'b0;
      r_cmd_ready  <= 1'b1;
      r_word_ready <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.cmd_valid) begin
            r_vd        <= bus.cmd_vd;
            r_vl        <= w_vl_clamp;
            r_vm        <= bus.cmd_vm;
            r_v0m       <= bus.v0[3:0];
            r_cnt       <= 3'd0;
            r_cmd_ready <= 1'b0;
            if (w_vl_clamp != 3'd0) begin
              r_state      <= COLLECT;
              r_word_ready <= 1'b1;
            end else begin
              // empty command: a single write cycle with no strobes
              r_state <= WRITE;
              r_we    <= 4'd0;
              r_done  <= 1'b1;
            end
          end
        end
        COLLECT: begin
          // abort takes priority even over the final word
          if (bus.abort) begin
            r_state      <= IDLE;
            r_cnt        <= 3'd0;
            r_buf        <= '0;
            r_word_ready <= 1'b0;
            r_cmd_ready  <= 1'b1;
          end else if (bus.word_valid) begin
            r_buf[{r_cnt[1:0], 5'd0} +: 32] <= bus.word_data;
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == r_vl - 3'd1) begin
              r_state      <= WRITE;
              r_word_ready <= 1'b0;
              r_we         <= w_we_final;
              r_done       <= 1'b1;
            end
          end
        end
        WRITE: begin
          r_state     <= IDLE;
          r_we        <= 4'd0;
          r_done      <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
        default: begin
          r_state      <= IDLE;
          r_we         <= 4'd0;
          r_done       <= 1'b0;
          r_cmd_ready  <= 1'b1;
          r_word_ready <= 1'b0;
        end
      endcase
    end
  end

  // address and data come straight from the latched fields; only valid with done
  assign bus.cmd_ready   = r_cmd_ready;
  assign bus.word_ready  = r_word_ready;
  assign bus.writeAddr   = r_vd;
  assign bus.writeVector = r_buf;
  assign bus.writeEnable = r_we;
  assign bus.done        = r_done;

endmodule

// File: tb/tb_vload_wb.sv
// Bench for vload_wb: scoreboard of expected register writes, popped on done.
// Inputs are driven 1 time unit after the rising edge; outputs sampled there too.
// Define VLOAD_WB_MASK_EN for both RTL and bench to exercise v0 masking.
module tb_vload_wb;

`ifdef VLOAD_WB_MASK_EN
  localparam bit MASK_EN = 1'b1;
`else
  localparam bit MASK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vload_wb_if #(.VLEN(128)) bus();
  vload_wb #(.VLEN(128)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [4:0]   addr;
    logic [127:0] vec;
    logic [3:0]   we;
    logic [127:0] keep;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  bit   started  = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_we(input logic [2:0] vl, input logic vm, input logic [3:0] v0lo);
    int n;
    logic [3:0] m;
    n = (vl > 3'd4) ? 4 : int'(vl);
    m = 4'b0000;
    for (int k = 0; k < n; k++) m[k] = 1'b1;
    if (MASK_EN && !vm) m = m & v0lo;
    return m;
  endfunction

  task automatic push_exp(input logic [4:0] vd, input logic [2:0] vl, input logic vm,
                          input logic [3:0] v0lo, input logic [127:0] words);
    exp_t e;
    int n;
    n = (vl > 3'd4) ? 4 : int'(vl);
    e.addr = vd;
    e.we   = model_we(vl, vm, v0lo);
    e.keep = '0;
    for (int k = 0; k < n; k++) e.keep[32*k +: 32] = 32'hFFFF_FFFF;
    e.vec  = words & e.keep;
    sb.push_back(e);
  endtask

  task automatic send_cmd(input logic [4:0] vd, input logic [2:0] vl, input logic vm, input logic [3:0] v0lo);
    int n;
    n = 0;
    bus.cmd_vd    = vd;
    bus.cmd_vl    = vl;
    bus.cmd_vm    = vm;
    bus.v0        = {$urandom(), $urandom(), $urandom(), 28'($urandom()), v0lo};
    bus.cmd_valid = 1'b1;
    while (bus.cmd_ready !== 1'b1 && n < 16) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.cmd_ready !== 1'b1) check("cmd_rdy_timeout", 128'(bus.cmd_ready), 128'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] data);
    int n;
    n = 0;
    bus.word_data  = data;
    bus.word_valid = 1'b1;
    while (bus.word_ready !== 1'b1 && n < 16) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.word_ready !== 1'b1) check("word_rdy_timeout", 128'(bus.word_ready), 128'd1);
    @(posedge clk); #1;
    bus.word_valid = 1'b0;
  endtask

  // full command; returns in the cycle where the write must be visible
  task automatic do_load(input logic [4:0] vd, input logic [2:0] vl, input logic vm,
                         input logic [3:0] v0lo, input logic [127:0] words);
    int n;
    n = (vl > 3'd4) ? 4 : int'(vl);
    push_exp(vd, vl, vm, v0lo, words);
    send_cmd(vd, vl, vm, v0lo);
    for (int k = 0; k < n; k++) send_word(words[32*k +: 32]);
    check("lat_done", 128'(bus.done), 128'd1);
  endtask

  // monitor: every done pulse must match the oldest expected write
  always @(posedge clk) begin
    #1;
    if (started) begin
      if (bus.done === 1'b1) begin
        if (sb.size() == 0) begin
          check("spurious_done", 128'(bus.done), 128'd0);
        end else begin
          mon_e = sb.pop_front();
          check("waddr", 128'(bus.writeAddr), 128'(mon_e.addr));
          check("wen", 128'(bus.writeEnable), 128'(mon_e.we));
          check("wvec", bus.writeVector & mon_e.keep, mon_e.vec);
        end
      end else begin
        check("we_idle", 128'(bus.writeEnable), 128'd0);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_vd     = '0;
    bus.cmd_vl     = '0;
    bus.cmd_vm     = 1'b1;
    bus.v0         = '0;
    bus.word_valid = 1'b0;
    bus.word_data  = '0;
    bus.abort      = 1'b0;
    rst            = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_cmd_ready", 128'(bus.cmd_ready), 128'd1);
    check("rst_word_ready", 128'(bus.word_ready), 128'd0);
    check("rst_done", 128'(bus.done), 128'd0);
    check("rst_we", 128'(bus.writeEnable), 128'd0);
    check("rst_addr", 128'(bus.writeAddr), 128'd0);
    check("rst_vec", bus.writeVector, 128'd0);
    started = 1'b1;

    // full vector, back-to-back words
    do_load(5'd3, 3'd4, 1'b1, 4'b0000, {32'h44, 32'h33, 32'h22, 32'h11});
    check("full_vec", bus.writeVector, 128'h00000044_00000033_00000022_00000011);
    @(posedge clk); #1;
    check("done_one_cycle", 128'(bus.done), 128'd0);
    check("idle_cmd_ready", 128'(bus.cmd_ready), 128'd1);

    // partial vector
    do_load(5'd7, 3'd2, 1'b1, 4'b0000, {64'd0, 32'hB, 32'hA});
    check("vl2_we", 128'(bus.writeEnable), 128'd3);

    // empty command: done lands in the second cycle of the command
    do_load(5'd9, 3'd0, 1'b1, 4'b0000, 128'd0);
    check("vl0_we", 128'(bus.writeEnable), 128'd0);

    // vl above 4 clamps to 4
    do_load(5'd12, 3'd6, 1'b1, 4'b0000, {32'hDEAD0004, 32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001});
    check("clamp_wrdy", 128'(bus.word_ready), 128'd0);

    // v0 masking (only effective when the mask feature is built in)
    do_load(5'd20, 3'd4, 1'b0, 4'b1010, {32'hC4, 32'hC3, 32'hC2, 32'hC1});
    check("mask_we", 128'(bus.writeEnable), MASK_EN ? 128'd10 : 128'd15);

    // abort after 2 of 4 words
    send_cmd(5'd1, 3'd4, 1'b1, 4'b0000);
    send_word(32'h1);
    send_word(32'h2);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("abort_cmd_ready", 128'(bus.cmd_ready), 128'd1);
    check("abort_word_ready", 128'(bus.word_ready), 128'd0);
    check("abort_done", 128'(bus.done), 128'd0);

    // abort coincident with the last word
    send_cmd(5'd2, 3'd4, 1'b1, 4'b0000);
    send_word(32'h1);
    send_word(32'h2);
    send_word(32'h3);
    bus.word_data  = 32'h4;
    bus.word_valid = 1'b1;
    bus.abort      = 1'b1;
    @(posedge clk); #1;
    bus.word_valid = 1'b0;
    bus.abort      = 1'b0;
    check("abort4_cmd_ready", 128'(bus.cmd_ready), 128'd1);
    check("abort4_done", 128'(bus.done), 128'd0);
    @(posedge clk); #1;
    check("abort4_done_late", 128'(bus.done), 128'd0);

    // reset in the middle of COLLECT
    send_cmd(5'd4, 3'd4, 1'b1, 4'b0000);
    send_word(32'hAAAA0001);
    send_word(32'hAAAA0002);
    send_word(32'hAAAA0003);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_cmd_ready", 128'(bus.cmd_ready), 128'd1);
    check("mrst_word_ready", 128'(bus.word_ready), 128'd0);
    check("mrst_done", 128'(bus.done), 128'd0);
    check("mrst_we", 128'(bus.writeEnable), 128'd0);
    check("mrst_addr", 128'(bus.writeAddr), 128'd0);
    check("mrst_vec", bus.writeVector, 128'd0);
    do_load(5'd6, 3'd1, 1'b1, 4'b0000, {96'd0, 32'h5A5A0001});
    check("mrst_then_we", 128'(bus.writeEnable), 128'd1);
    check("mrst_then_lane0", 128'(bus.writeVector[31:0]), 128'h5A5A0001);

    // word_valid toggling 1,0,1: counter moves only on handshakes
    push_exp(5'd15, 3'd2, 1'b1, 4'b0000, {64'd0, 32'hBEEF0002, 32'hBEEF0001});
    send_cmd(5'd15, 3'd2, 1'b1, 4'b0000);
    bus.word_data  = 32'hBEEF0001;
    bus.word_valid = 1'b1;
    @(posedge clk); #1;
    bus.word_valid = 1'b0;
    bus.word_data  = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    check("tog_gap_done", 128'(bus.done), 128'd0);
    check("tog_gap_wrdy", 128'(bus.word_ready), 128'd1);
    bus.word_data  = 32'hBEEF0002;
    bus.word_valid = 1'b1;
    @(posedge clk); #1;
    bus.word_valid = 1'b0;
    check("tog_done", 128'(bus.done), 128'd1);
    check("tog_lanes", 128'(bus.writeVector[63:0]), 128'h00000000_00000000_BEEF0002_BEEF0001);

    repeat (3) @(posedge clk);
    #2;
    check("sb_empty", 128'(sb.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
